uart_tx_arbiter: RTL and testbench

//  Shares one uart_byte_tx byte transmitter between NUM_REQ independent byte sources (status echo, ack, telemetry...).

---
 rtl/uart_tx_arbiter_pkg.sv | 12 +
 rtl/uart_rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state codes and baud-rate codes
// understood by uart_byte_tx.
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam logic [2:0] BAUD_115200  = 3'd4;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: returns the first requester at or after ptr_i,
// wrapping modulo NUM_REQ.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               gnt_valid_o,
    output logic [PTR_W-1:0]   gnt_idx_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = '0;
        // Walk from the farthest offset down so the closest requester to ptr_i is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                gnt_idx_o = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_byte_tx between NUM_REQ byte sources, with
// completion/timeout reporting and an inter-byte idle gap.
//
// state        | meaning
// ST_IDLE      | arbitrating; winner latched into owner/tx_data
// ST_LAUNCH    | send_en and ack pulse high, pointer advances
// ST_WAIT_DONE | waiting for tx_done, watchdog timer running
// ST_GAP       | enforced idle clocks before the next arbitration
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 200000,
    parameter logic [2:0] BAUD_SET   = BAUD_115200
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic                   busy,
    output logic [2:0]             baud_set,
    output logic                   send_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [1:0]         state_q,   state_d;
    logic [PTR_W-1:0]   ptr_q,     ptr_d;
    logic [PTR_W-1:0]   owner_q,   owner_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [TMR_W-1:0]   timer_q,   timer_d;
    logic [GAP_W-1:0]   gap_q,     gap_d;
    logic [NUM_REQ-1:0] ack_q,     ack_d;
    logic [NUM_REQ-1:0] done_q,    done_d;
    logic [NUM_REQ-1:0] err_q,     err_d;
    logic               send_en_q, send_en_d;

    logic               gnt_valid;
    logic [PTR_W-1:0]   gnt_idx;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = '0;
        send_en_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Pulses are registered here so they are high for exactly the LAUNCH cycle.
                if (gnt_valid) begin
                    owner_d        = gnt_idx;
                    tx_data_d      = req_data[int'(gnt_idx)*8 +: 8];
                    ack_d[gnt_idx] = 1'b1;
                    send_en_d      = 1'b1;
                    timer_d        = '0;
                    state_d        = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                timer_d = timer_q + 1'b1;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done || (timer_q == TMR_W'(TIMEOUT - 1))) begin
                    if (tx_done) begin
                        done_d[owner_q] = 1'b1;
                    end else begin
                        err_d[owner_q] = 1'b1;
                    end
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            tx_data_q <= '0;
            timer_q   <= '0;
            gap_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            send_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            send_en_q <= send_en_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign err      = err_q;
    assign send_en  = send_en_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign baud_set = BAUD_SET;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level model predicts the winner of
// each arbitration and the cycle on which each ack/done/err pulse must appear.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 4;
    localparam int TMO  = 50;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic [2:0]        baud_set;
    logic              send_en;
    logic [7:0]        tx_data;
    logic              tx_done;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    logic [7:0] m_byte = '0;

    uart_tx_arbiter #(
        .NUM_REQ    (NREQ),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO),
        .BAUD_SET   (3'd4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .baud_set (baud_set),
        .send_en  (send_en),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_send, input logic [NREQ-1:0] e_ack,
                              input logic [NREQ-1:0] e_done, input logic [NREQ-1:0] e_err,
                              input logic e_busy);
        check_eq({tag, ".send_en"}, 32'(send_en), 32'(e_send));
        check_eq({tag, ".ack"},     32'(ack),     32'(e_ack));
        check_eq({tag, ".done"},    32'(done),    32'(e_done));
        check_eq({tag, ".err"},     32'(err),     32'(e_err));
        check_eq({tag, ".busy"},    32'(busy),    32'(e_busy));
    endtask

    // First requester at or after p, wrapping; -1 when nobody requests.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic add_reqs(input logic [NREQ-1:0] bits);
        for (int i = 0; i < NREQ; i++) begin
            if (bits[i] && !req[i]) begin
                req_data[i*8 +: 8] = 8'($urandom);
                req[i] = 1'b1;
            end
        end
    endtask

    // Entered while the DUT is idle with req nonzero; returns with the DUT idle again.
    // d > 0: tx_done returned d clocks after send_en; d <= 0: never returned (timeout).
    task automatic run_txn(input int d, input bit keep);
        int w;
        int last;
        logic [NREQ-1:0] oh;
        w  = pick(req, m_ptr);
        oh = NREQ'(1) << w;
        m_byte = req_data[w*8 +: 8];
        tick();
        check_outs("launch", 1'b1, oh, '0, '0, 1'b1);
        check_eq("launch.tx_data", 32'(tx_data), 32'(m_byte));
        m_ptr = (w + 1) % NREQ;
        if (!keep) req[w] = 1'b0;
        last = (d > 0) ? d : TMO - 1;
        for (int k = 1; k <= last; k++) begin
            tick();
            check_outs("wait", 1'b0, '0, '0, '0, 1'b1);
            if (d > 0 && k == d) tx_done = 1'b1;
        end
        tick();
        tx_done = 1'b0;
        if (d > 0) check_outs("complete", 1'b0, '0, oh, '0, 1'b1);
        else       check_outs("timeout",  1'b0, '0, '0, oh, 1'b1);
        check_eq("gap.tx_data", 32'(tx_data), 32'(m_byte));
        for (int g = 1; g < GAP; g++) begin
            tx_done = ($urandom_range(0, 3) == 0);
            tick();
            tx_done = 1'b0;
            check_outs("gap", 1'b0, '0, '0, '0, 1'b1);
        end
        tick();
        check_outs("idle", 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        int r;
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;
        tick();
        tick();
        check_outs("reset", 1'b0, '0, '0, '0, 1'b0);
        check_eq("reset.tx_data", 32'(tx_data), 32'h0);
        check_eq("baud_set", 32'(baud_set), 32'h4);
        reset_n = 1'b1;
        tick();
        check_outs("post_reset", 1'b0, '0, '0, '0, 1'b0);

        // All four sources at once: grants must come out 0,1,2,3.
        req_data = 32'h13121110;
        req      = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            run_txn($urandom_range(1, 12), 1'b0);
            check_eq("contention.byte", 32'(m_byte), 32'(8'h10 + i));
        end

        // Single source, tx_done 10 clocks after send_en.
        req_data[23:16] = 8'hA5;
        req[2] = 1'b1;
        run_txn(10, 1'b0);

        // Wrap: source 3 keeps requesting, source 0 joins; 0 must go before 3 again.
        req[3] = 1'b1;
        run_txn(5, 1'b1);
        add_reqs(4'b0001);
        run_txn(3, 1'b0);
        run_txn(3, 1'b0);

        // Watchdog expiry, then tx_done on the very last legal clock.
        add_reqs(4'b0100);
        run_txn(0, 1'b0);
        add_reqs(4'b0010);
        run_txn(TMO - 1, 1'b0);

        // Stray tx_done while idle must not produce anything.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_outs("stray_done", 1'b0, '0, '0, '0, 1'b0);
        tick();
        check_outs("stray_done2", 1'b0, '0, '0, '0, 1'b0);

        // Reset in the middle of a byte: pointer must return to 0, late tx_done ignored.
        while (pick(4'b0001, m_ptr) != 0 || m_ptr != 0) begin
            add_reqs(NREQ'(1) << m_ptr);
            run_txn(2, 1'b0);
        end
        add_reqs(4'b0001);
        tick();
        check_outs("mid.launch", 1'b1, 4'b0001, '0, '0, 1'b1);
        req[0] = 1'b0;
        r = $urandom_range(2, 8);
        for (int k = 0; k < r; k++) tick();
        reset_n = 1'b0;
        tick();
        check_outs("mid.reset", 1'b0, '0, '0, '0, 1'b0);
        check_eq("mid.reset.tx_data", 32'(tx_data), 32'h0);
        reset_n = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_outs("mid.late_done", 1'b0, '0, '0, '0, 1'b0);
        m_ptr = 0;
        add_reqs(4'b0011);
        run_txn(4, 1'b0);
        check_eq("mid.regrant", 32'(m_ptr), 32'd1);

        // Randomized traffic, including dropped requests and held re-requests.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, NREQ - 1)] = 1'b0;
            add_reqs(NREQ'($urandom_range(0, 15)));
            if (req == '0) add_reqs(NREQ'(1) << $urandom_range(0, NREQ - 1));
            r = $urandom_range(0, 9);
            if (r == 0)      run_txn(0, $urandom_range(0, 3) == 0);
            else if (r == 1) run_txn(TMO - 1, $urandom_range(0, 3) == 0);
            else             run_txn($urandom_range(1, 12), $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
